// File: rtl/mux_2x1_rr_arbiter_if.sv
// Handshake bundle between producers A/B, the round-robin stage and its consumer.
// The slave modport is the arbiter side; the master modport is the environment side.
interface mux_2x1_rr_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             a_valid;
   logic [WIDTH-1:0] a_data;
   logic             a_ready;
   logic             b_valid;
   logic [WIDTH-1:0] b_data;
   logic             b_ready;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_ready;
   logic             select;

   modport slave (
      input  a_valid, a_data, b_valid, b_data, m_ready,
      output a_ready, b_ready, m_valid, m_data, select
   );

   modport master (
      output a_valid, a_data, b_valid, b_data, m_ready,
      input  a_ready, b_ready, m_valid, m_data, select
   );
endinterface

// File: rtl/mux_2x1_rr_arbiter.sv
// Two 1-entry input buffers, a round-robin pick between them and a registered
// output word with a select bit (1=A, 0=B) for the downstream 2-to-1 mux.

module mux_2x1_rr_arbiter_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_b,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_drain,
   output logic             o_full,
   output logic [WIDTH-1:0] o_data
);
   logic             r_full;
   logic [WIDTH-1:0] r_data;

   // Load only while empty, so a buffer drained this edge refills next edge at the earliest.
   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_drain) begin
         r_full <= 1'b0;
      end else if (i_valid && !r_full) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end
   end

   assign o_full = r_full;
   assign o_data = r_data;
endmodule

module mux_2x1_rr_arbiter #(
   parameter int WIDTH = 8
) (
   input logic                  clock,
   input logic                  reset_b,
   mux_2x1_rr_arbiter_if.slave  bus
);
   localparam int SRC_A = 1;
   localparam int SRC_B = 0;

   typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

   pri_t                  r_pri, w_pri_nxt;
   logic [1:0]            w_in_valid;
   logic [1:0][WIDTH-1:0] w_in_data;
   logic [1:0]            w_full;
   logic [1:0][WIDTH-1:0] w_buf_data;
   logic [1:0]            w_drain;
   logic                  w_out_free;
   logic                  r_m_valid;
   logic [WIDTH-1:0]      r_m_data;
   logic                  r_select;

   assign w_in_valid[SRC_A] = bus.a_valid;
   assign w_in_valid[SRC_B] = bus.b_valid;
   assign w_in_data[SRC_A]  = bus.a_data;
   assign w_in_data[SRC_B]  = bus.b_data;

   for (genvar g = 0; g < 2; g++) begin : g_ch
      mux_2x1_rr_arbiter_buf #(.WIDTH(WIDTH)) u_buf (
         .clock   (clock),
         .reset_b (reset_b),
         .i_valid (w_in_valid[g]),
         .i_data  (w_in_data[g]),
         .i_drain (w_drain[g]),
         .o_full  (w_full[g]),
         .o_data  (w_buf_data[g])
      );
   end

   assign w_out_free = ~r_m_valid | bus.m_ready;

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) r_pri <= PRI_A;
      else          r_pri <= w_pri_nxt;
   end

   // A lone full buffer always wins; the pointer only breaks ties.
   always_comb begin
      w_drain   = '0;
      w_pri_nxt = r_pri;
      if (w_out_free) begin
         if (w_full[SRC_A] && (!w_full[SRC_B] || r_pri == PRI_A)) begin
            w_drain[SRC_A] = 1'b1;
            w_pri_nxt      = PRI_B;
         end else if (w_full[SRC_B]) begin
            w_drain[SRC_B] = 1'b1;
            w_pri_nxt      = PRI_A;
         end
      end
   end

   // Data and select only move on a transfer; an empty cycle just drops valid.
   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_select  <= 1'b0;
      end else if (w_out_free) begin
         r_m_valid <= |w_drain;
         if (|w_drain) begin
            r_m_data <= w_drain[SRC_A] ? w_buf_data[SRC_A] : w_buf_data[SRC_B];
            r_select <= w_drain[SRC_A];
         end
      end
   end

   assign bus.a_ready = ~w_full[SRC_A];
   assign bus.b_ready = ~w_full[SRC_B];
   assign bus.m_valid = r_m_valid;
   assign bus.m_data  = r_m_data;
   assign bus.select  = r_select;

   a_one_drain: assert property (@(posedge clock) disable iff (!reset_b) $onehot0(w_drain));
   a_hold: assert property (@(posedge clock) disable iff (!reset_b)
      (r_m_valid && !bus.m_ready) |=> (r_m_valid && $stable(r_m_data) && $stable(r_select)));
endmodule

// File: tb/tb_mux_2x1_rr_arbiter.sv
// Directed scenarios plus random traffic, checked each cycle against a queue-based
// model of the two buffers and the output word, and against per-channel order.
module tb_mux_2x1_rr_arbiter;
   localparam int WIDTH = 8;

   logic clock = 1'b0;
   logic reset_b = 1'b1;

   mux_2x1_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();
   mux_2x1_rr_arbiter #(.WIDTH(WIDTH)) dut (.clock(clock), .reset_b(reset_b), .bus(bus));

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

   // model state
   logic [7:0] mqa[$];
   logic [7:0] mqb[$];
   bit         mv;
   logic [7:0] md;
   bit         ms;
   bit         fav_a;

   // stimulus and scoreboard
   logic [7:0] a_src[$];
   logic [7:0] b_src[$];
   logic [7:0] sa[$];
   logic [7:0] sb[$];
   logic [8:0] outs[$];
   bit         rnd = 0;
   int         mr_mode = 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mqa.delete(); mqb.delete();
      mv = 0; md = 8'h00; ms = 0; fav_a = 1;
   endtask

   task automatic model_edge();
      bit fa, fb, ld_a, ld_b;
      fa = mqa.size() != 0;
      fb = mqb.size() != 0;
      ld_a = bus.a_valid && !fa;
      ld_b = bus.b_valid && !fb;
      if (!mv || bus.m_ready) begin
         if (fa && (!fb || fav_a)) begin
            md = mqa.pop_front(); ms = 1; mv = 1; fav_a = 0;
         end else if (fb) begin
            md = mqb.pop_front(); ms = 0; mv = 1; fav_a = 1;
         end else begin
            mv = 0;
         end
      end
      if (ld_a) mqa.push_back(bus.a_data);
      if (ld_b) mqb.push_back(bus.b_data);
   endtask

   task automatic compare_model();
      chk("a_ready", bus.a_ready, mqa.size() == 0);
      chk("b_ready", bus.b_ready, mqb.size() == 0);
      chk("m_valid", bus.m_valid, mv);
      chk("m_data", bus.m_data, md);
      chk("select", bus.select, ms);
   endtask

   task automatic drive();
      bit ea, eb;
      ea = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      eb = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.a_valid = ea && (a_src.size() != 0);
      bus.a_data  = bus.a_valid ? a_src[0] : 8'($urandom);
      bus.b_valid = eb && (b_src.size() != 0);
      bus.b_data  = bus.b_valid ? b_src[0] : 8'($urandom);
      bus.m_ready = (mr_mode == 2) ? 1'($urandom_range(0, 1)) : (mr_mode == 1);
   endtask

   task automatic order_pop(input bit from_a, input logic [7:0] d);
      if (from_a ? (sa.size() == 0) : (sb.size() == 0)) begin
         n_chk++; n_err++;
         $display("FAIL order: got %0h from %s, expected no word pending", d, from_a ? "A" : "B");
      end else if (from_a) chk("order_a", d, sa.pop_front());
      else                 chk("order_b", d, sb.pop_front());
   endtask

   task automatic cycle();
      bit ha, hb, hm;
      ha = bus.a_valid && bus.a_ready;
      hb = bus.b_valid && bus.b_ready;
      hm = bus.m_valid && bus.m_ready;
      if (ha) sa.push_back(bus.a_data);
      if (hb) sb.push_back(bus.b_data);
      if (hm) begin
         outs.push_back({bus.select, bus.m_data});
         order_pop(bus.select, bus.m_data);
      end
      @(posedge clock);
      model_edge();
      #1;
      if (ha) void'(a_src.pop_front());
      if (hb) void'(b_src.pop_front());
      compare_model();
      drive();
   endtask

   // Entered between edges; reset asserts asynchronously and releases on a falling edge.
   task automatic hard_reset();
      #2;
      reset_b = 1'b0;
      a_src.delete(); b_src.delete(); sa.delete(); sb.delete(); outs.delete();
      model_reset();
      bus.a_valid = 0; bus.b_valid = 0;
      #1;
      chk("rst_a_ready", bus.a_ready, 1);
      chk("rst_b_ready", bus.b_ready, 1);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_data", bus.m_data, 0);
      chk("rst_select", bus.select, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_b = 1'b1;
      drive();
   endtask

   task automatic chk_outs(input string nm, input logic [8:0] exp[$]);
      chk({nm, "_count"}, outs.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         if (i < outs.size()) chk($sformatf("%s_%0d", nm, i), outs[i], exp[i]);
   endtask

   initial begin
      bus.a_valid = 0; bus.a_data = 0; bus.b_valid = 0; bus.b_data = 0; bus.m_ready = 0;
      model_reset();
      hard_reset();

      // A only
      mr_mode = 1; a_src = '{8'h11}; drive();
      cycle();
      chk("t1_a_ready_busy", bus.a_ready, 0);
      chk("t1_m_valid_early", bus.m_valid, 0);
      cycle();
      chk("t1_m_valid", bus.m_valid, 1);
      chk("t1_m_data", bus.m_data, 8'h11);
      chk("t1_select", bus.select, 1);
      chk("t1_a_ready_free", bus.a_ready, 1);
      cycle();
      chk("t1_m_valid_drop", bus.m_valid, 0);

      // both loaded together, pointer favours A after reset
      hard_reset();
      a_src = '{8'hA0}; b_src = '{8'hB0}; drive();
      cycle();
      cycle();
      chk("t2_first", {bus.select, bus.m_data}, 9'h1A0);
      cycle();
      chk("t2_second", {bus.select, bus.m_data}, 9'h0B0);
      cycle();
      chk_outs("t2", '{9'h1A0, 9'h0B0});

      // interleaved streams keep the output busy every cycle
      hard_reset();
      a_src = '{8'h01, 8'h02, 8'h03}; b_src = '{8'h81, 8'h82, 8'h83}; drive();
      cycle();
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk($sformatf("t3_busy_%0d", i), bus.m_valid, 1);
      end
      repeat (3) cycle();
      chk_outs("t3", '{9'h101, 9'h081, 9'h102, 9'h082, 9'h103, 9'h083});

      // backpressure with both buffers full behind 5A
      hard_reset();
      mr_mode = 0; a_src = '{8'h5A, 8'hA1}; b_src = '{8'hB1}; drive();
      repeat (3) cycle();
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t4_hold_word", {bus.m_valid, bus.select, bus.m_data}, 10'h35A);
         chk("t4_hold_ready", {bus.a_ready, bus.b_ready}, 2'b00);
      end
      mr_mode = 1; drive();
      repeat (5) cycle();
      chk_outs("t4", '{9'h15A, 9'h0B1, 9'h1A1});

      // reset while a word is on the output
      hard_reset();
      a_src = '{8'h31, 8'h32}; b_src = '{8'h41, 8'h42}; drive();
      repeat (3) cycle();
      chk("t5_busy", bus.m_valid, 1);
      hard_reset();
      b_src = '{8'hC5}; drive();
      repeat (4) cycle();
      chk_outs("t5", '{9'h0C5});

      // single channel runs at half rate
      hard_reset();
      b_src = '{8'hC0, 8'hC1, 8'hC2, 8'hC3}; drive();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t6_b_ready_%0d", i), bus.b_ready, (i % 2) == 0);
         cycle();
      end
      repeat (8) cycle();
      chk_outs("t6", '{9'h0C0, 9'h0C1, 9'h0C2, 9'h0C3});

      // random traffic with occasional resets
      hard_reset();
      rnd = 1; mr_mode = 2;
      for (int i = 0; i < 3000; i++) begin
         if (a_src.size() < 2) a_src.push_back(8'($urandom));
         if (b_src.size() < 2) b_src.push_back(8'($urandom));
         cycle();
         if (i % 700 == 699) hard_reset();
      end
      rnd = 0; mr_mode = 1;
      a_src.delete(); b_src.delete(); drive();
      repeat (6) cycle();
      chk("rnd_drained_a", sa.size(), 0);
      chk("rnd_drained_b", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/mux_2x1_rr_arbiter.md
Name: mux_2x1_rr_arbiter

Overview:
- Upstream control-and-data stage for the team's 2-to-1 multiplexer.
- Accepts words from two independent valid/ready producers, A and B, and holds each in a 1-entry buffer.
- Chooses between the buffered words round-robin and presents the winner on a registered valid/ready output.
- Drives the registered `select` that identifies the source of the current output word. Encoding matches the team's mux: select=1 means A, select=0 means B.

Parameters:
- WIDTH, 8, data width of A, B and output words.

Ports:
- clock  input  1  rising-edge clock
- reset_b  input  1  asynchronous active-low reset
- a_valid  input  1  producer A has a word on a_data
- a_data  input  WIDTH  producer A word
- a_ready  output  1  A buffer empty; A handshake occurs when a_valid & a_ready at clock edge
- b_valid  input  1  producer B has a word on b_data
- b_data  input  WIDTH  producer B word
- b_ready  output  1  B buffer empty; B handshake occurs when b_valid & b_ready at clock edge
- m_valid  output  1  output register holds a word
- m_data  output  WIDTH  output word
- m_ready  input  1  consumer accepts; output handshake occurs when m_valid & m_ready at clock edge
- select  output  1  source of m_data: 1=A, 0=B; feeds downstream mux select

Behaviour:
- Reset (reset_b=0, asynchronous, immediate):
  - a_full=0, b_full=0, m_valid=0, m_data=0, select=0.
  - Priority pointer favours A.
  - Outputs a_ready=1 and b_ready=1 once reset_b=0.
  - Reset mid-transfer discards all buffered and output words; no partial word is ever emitted.
- Input buffers:
  - a_ready = ~a_full and b_ready = ~b_full. These depend only on registered state, never combinationally on any input.
  - A handshake at edge k loads the buffer and sets its full flag.
  - A buffer that drains at edge k cannot be refilled at edge k. The refill occurs at edge k+1 at the earliest.
  - Per-channel throughput is therefore at most 1 word per 2 cycles.
- Output register:
  - Define out_free = ~m_valid | m_ready.
  - At an edge where out_free=1 and at least one buffer is full, exactly one buffer transfers to the output register:
    - m_data takes the buffer word.
    - select is set to 1 if the word came from A, 0 if from B.
    - m_valid=1.
    - The source buffer's full flag clears.
  - If out_free=1 and both buffers are empty: m_valid goes 0, m_data holds its last value, select holds.
  - If out_free=0: m_valid, m_data and select hold, and both buffers hold.
  - m_data and select are stable while m_valid=1 & m_ready=0.
- Arbitration:
  - Only one buffer full: it wins regardless of pointer.
  - Both full: the pointer decides.
  - Pointer update: after a transfer from A it favours B; after a transfer from B it favours A. It updates only on a transfer.
  - Starvation bound: a full buffer waits at most one output transfer.
- Latency: input handshake at edge k; m_valid=1 after edge k+1 if the output is free. Minimum latency is 1 cycle from buffer to output; 2 edges from input presentation.
- Aggregate throughput: 1 word per cycle with both producers active and m_ready held at 1.
- Simultaneous events in one edge are all legal and independent:
  - A load.
  - B load.
  - Output handshake plus buffer-to-output transfer.
- Ordering: words from one channel leave in acceptance order. Nothing is ever dropped or duplicated.
- X handling: a_data and b_data are ignored when the matching valid is 0.

Test Plan:
- Reset, then A only: a_data=8'h11, a_valid=1 for one cycle, m_ready=1 -> a_ready=0 for 1 cycle; m_valid=1, m_data=8'h11, select=1 one cycle later; then m_valid=0.
- Both producers loaded the same cycle with A=8'hA0 and B=8'hB0, m_ready=1 -> output sequence A0 (select=1) then B0 (select=0) on consecutive cycles.
- Continuous streams A=8'h01,02,03 and B=8'h81,82,83, m_ready=1 -> output alternates 01,81,02,82,03,83; select toggles 1,0,1,0,…; m_valid stays 1 once the stream starts.
- Backpressure: m_ready=0 for 5 cycles with the output holding 8'h5A and both buffers full -> m_data=8'h5A and select are stable; a_ready=b_ready=0. After m_ready=1, the remaining words drain in pointer order with no loss.
- Mid-stream reset: assert reset_b=0 asynchronously between edges while m_valid=1 -> m_valid=0, select=0 and a_ready=b_ready=1 immediately. After release, the first B-only word appears with select=0.
- Single-channel rate: B streams 8'hC0..C3 with valid held, A idle -> b_ready pattern is 1,0,1,0; outputs C0..C3 come in order with select=0 throughout.
